maoin_led_seq: RTL and testbench
================================

MAOIN_LED_SEQ -- requirements
Module: maoin_led_seq

Interface
REQ-001 SHALL have parameter PERIOD_W, default 32, width of the tick-period register and counter.
REQ-002 SHALL have parameter RESET_PERIOD, default 50000000, PERIOD register value after reset.
REQ-003 SHALL have clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have s_address  in  2  config slave word address.
REQ-006 SHALL have s_chipselect, s_write_n, s_read_n  in  1 each  config slave strobes, active as named.
REQ-007 SHALL have s_writedata  in  32, and s_readdata  out  32, with zero-wait-state combinational readback.
REQ-008 SHALL have m_address  out  2  LED PIO word address, constant 0.
REQ-009 SHALL have m_write  out  1, m_writedata  out  32, and m_waitrequest  in  1, forming an Avalon-MM write master to the LED PIO.
REQ-010 SHALL have irq  out  1  level interrupt on sequence wrap.

Function
REQ-011 SHALL decode slave registers: 0 CTRL (bit0 EN, bits2:1 MODE, bit3 IRQ_EN), 1 PERIOD (PERIOD_W bits), 2 PATTERN (bits7:0 seed/static value), 3 STATUS (bit0 BUSY, bit1 WRAP, bits15:8 current pattern).
REQ-012 SHALL read unused register bits as 0; STATUS SHALL be read-only except that writing 1 to bit1 clears WRAP.
REQ-013 SHALL implement FSM states IDLE, LOAD, WAIT_TICK, WRITE.
REQ-014 SHALL move IDLE->LOAD on EN=1, load cur=PATTERN, and clear the tick counter.
REQ-015 SHALL move LOAD->WRITE next cycle so that the seed is output first.
REQ-016 SHALL, in WRITE, assert m_write with m_writedata={24'b0,cur}, hold both stable while m_waitrequest=1, then go to WAIT_TICK the cycle after m_waitrequest=0.
REQ-017 SHALL, in WAIT_TICK, count clk cycles and at count=PERIOD-1 compute the next cur per MODE and enter WRITE; PERIOD=0 SHALL behave as PERIOD=1.
REQ-018 MODE 0 chaser: rotate-left cur by 1; wrap event when the result equals PATTERN.
REQ-019 MODE 1 ping-pong: shift in direction DIR; when bit7 (left) or bit0 (right) is set before shifting, invert DIR and shift the other way; wrap event on each return to bit0.
REQ-020 MODE 2 counter: cur+1 modulo 256; wrap event on 255->0.
REQ-021 MODE 3 static: cur=PATTERN, re-sampled each tick; no wrap event.
REQ-022 SHALL, on a wrap event, set WRAP; irq SHALL equal WRAP AND IRQ_EN.
REQ-023 SHALL, when EN is cleared in WAIT_TICK, go to IDLE next cycle; when cleared in WRITE, complete the pending write and then go to IDLE.
REQ-024 SHALL apply PERIOD, MODE and PATTERN writes made while running at the next tick without restarting the counter; a PERIOD lowered below the current count SHALL fire the tick on the next cycle.
REQ-025 SHALL set BUSY=1 in every state other than IDLE.
REQ-026 SHALL, when a WRAP-clear and a wrap event occur in the same cycle, leave WRAP set.

Reset
REQ-027 SHALL, on reset_n=0, asynchronously set FSM=IDLE, CTRL=0, PERIOD=RESET_PERIOD, PATTERN=8'h01, cur=0, DIR=left, WRAP=0, count=0, m_write=0, m_writedata=0, irq=0.
REQ-028 SHALL, on reset asserted mid-write, drop m_write immediately; no write completion is required.

Structure
REQ-029 SHALL place register offsets, CTRL bit positions, MODE encodings and the FSM state enumeration in shared package maoin_led_pkg.
REQ-030 SHALL implement next-pattern generation as combinational sub-module maoin_led_pattern_next (inputs cur, mode, dir, pattern; outputs next, next_dir, wrap).

Verification
REQ-031 PERIOD=4, PATTERN=8'h01, MODE=0, EN=1, m_waitrequest=0 -> writes 01,02,04,...,80,01 spaced 5 clk; WRAP set on the 01 write.
REQ-032 MODE=1, PERIOD=1 -> sequence 01,02,...,80,40,...,01; DIR flips at 80 and at 01.
REQ-033 MODE=2, PATTERN=8'hFE, IRQ_EN=1 -> FE,FF,00; irq rises with the 00 write; write STATUS bit1=1 -> irq=0.
REQ-034 m_waitrequest held high 7 cycles during a write -> m_write and m_writedata stable for all 7 cycles; next tick counted only after acceptance.
REQ-035 EN cleared during a stalled write -> write completes once, then BUSY=0 and no further m_write.
REQ-036 reset_n pulsed low mid-WAIT_TICK -> all REQ-027 values present in the same cycle; readback of PERIOD=RESET_PERIOD.

Source files
------------

// File: rtl/maoin_led_pkg.sv
// Shared definitions for the LED sequencer:
// register map, CTRL/STATUS bit positions, modes and FSM states.
package maoin_led_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IRQ_EN   = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_WRAP    = 1;
    localparam int STAT_CUR_LSB = 8;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        MODE_CHASER   = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_COUNTER  = 2'd2,
        MODE_STATIC   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_TICK = 2'd2,
        ST_WRITE     = 2'd3
    } state_e;

    function automatic logic [7:0] rol8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/maoin_led_seq_if.sv
// Bus bundle of the LED sequencer: config slave port,
// LED PIO write master port and the wrap interrupt.
interface maoin_led_seq_if;

    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic        s_read_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    logic [1:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    logic        irq;

    modport slave (
        input  s_address, s_chipselect, s_write_n, s_read_n, s_writedata,
        output s_readdata,
        output m_address, m_write, m_writedata,
        input  m_waitrequest,
        output irq
    );

    modport master (
        output s_address, s_chipselect, s_write_n, s_read_n, s_writedata,
        input  s_readdata,
        input  m_address, m_write, m_writedata,
        output m_waitrequest,
        input  irq
    );

endinterface

// File: rtl/maoin_led_pattern_next.sv
// Next-pattern generator: pure combinational step of the
// current LED pattern for the selected mode.
module maoin_led_pattern_next
    import maoin_led_pkg::*;
(
    input  logic [7:0] cur,
    input  mode_e      mode,
    input  logic       dir,
    input  logic [7:0] pattern,
    output logic [7:0] next,
    output logic       next_dir,
    output logic       wrap
);

    logic w_right;

    // Step the pattern; ping-pong bounces off bit7/bit0 and wraps on reaching bit0
    always_comb begin
        next     = cur;
        next_dir = dir;
        wrap     = 1'b0;
        w_right  = 1'b0;
        unique case (mode)
            MODE_CHASER: begin
                next = rol8(cur);
                wrap = (rol8(cur) == pattern);
            end
            MODE_PINGPONG: begin
                if (dir == DIR_LEFT) begin
                    w_right  = cur[7];
                    next_dir = cur[7] ? DIR_RIGHT : DIR_LEFT;
                end else begin
                    w_right  = ~cur[0];
                    next_dir = cur[0] ? DIR_LEFT : DIR_RIGHT;
                end
                next = w_right ? (cur >> 1) : (cur << 1);
                wrap = w_right & cur[1];
            end
            MODE_COUNTER: begin
                next = cur + 8'd1;
                wrap = (cur == 8'hFF);
            end
            MODE_STATIC: begin
                next = pattern;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/maoin_led_seq.sv
// LED sequencer: config registers, tick timer and FSM that
// pushes one LED pattern per tick to a PIO over Avalon-MM.
module maoin_led_seq
    import maoin_led_pkg::*;
#(
    parameter int          PERIOD_W     = 32,
    parameter int unsigned RESET_PERIOD = 50000000
) (
    input logic            clk,
    input logic            reset_n,
    maoin_led_seq_if.slave bus
);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_en;
    logic                r_irq_en;
    mode_e               r_mode;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_count;
    logic [7:0]          r_pattern;
    logic [7:0]          r_cur;
    logic                r_dir;
    logic                r_wrap;

    logic                w_wr;
    logic                w_rd;
    logic [PERIOD_W-1:0] w_period_eff;
    logic                w_tick;
    logic [7:0]          w_next;
    logic                w_next_dir;
    logic                w_wrap_raw;
    logic                w_wrap_evt;
    logic                w_wrap_clr;
    logic                w_busy;

    assign w_wr = bus.s_chipselect & ~bus.s_write_n;
    assign w_rd = bus.s_chipselect & ~bus.s_read_n;

    // A zero period would never tick; treat it as one cycle.
    // ">=" lets a period lowered under the running count fire at once.
    assign w_period_eff = (r_period == '0) ? PERIOD_W'(1) : r_period;
    assign w_tick       = (r_count >= (w_period_eff - PERIOD_W'(1)));

    assign w_wrap_evt = (r_state == ST_WAIT_TICK) & r_en & w_tick & w_wrap_raw;
    assign w_wrap_clr = w_wr & (bus.s_address == ADDR_STATUS)
                      & bus.s_writedata[STAT_WRAP];
    assign w_busy     = (r_state != ST_IDLE);

    maoin_led_pattern_next u_next (
        .cur      (r_cur),
        .mode     (r_mode),
        .dir      (r_dir),
        .pattern  (r_pattern),
        .next     (w_next),
        .next_dir (w_next_dir),
        .wrap     (w_wrap_raw)
    );

    // Config register writes from the slave port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= 1'b0;
            r_irq_en  <= 1'b0;
            r_mode    <= MODE_CHASER;
            r_period  <= PERIOD_W'(RESET_PERIOD);
            r_pattern <= 8'h01;
        end else if (w_wr) begin
            case (bus.s_address)
                ADDR_CTRL: begin
                    r_en     <= bus.s_writedata[CTRL_EN];
                    r_mode   <= mode_e'(bus.s_writedata[CTRL_MODE_LSB +: 2]);
                    r_irq_en <= bus.s_writedata[CTRL_IRQ_EN];
                end
                ADDR_PERIOD:  r_period  <= bus.s_writedata[PERIOD_W-1:0];
                ADDR_PATTERN: r_pattern <= bus.s_writedata[7:0];
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next state; a write in flight always completes before IDLE
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_en) w_state_next = ST_LOAD;
            end
            ST_LOAD: w_state_next = ST_WRITE;
            ST_WAIT_TICK: begin
                if (!r_en)       w_state_next = ST_IDLE;
                else if (w_tick) w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (!bus.m_waitrequest)
                    w_state_next = r_en ? ST_WAIT_TICK : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: write strobe/data straight from state and held pattern
    always_comb begin
        bus.m_address   = 2'b00;
        bus.m_write     = (r_state == ST_WRITE);
        bus.m_writedata = (r_state == ST_WRITE) ? {24'b0, r_cur} : 32'b0;
        bus.irq         = r_wrap & r_irq_en;
    end

    // Pattern, direction and tick counter; counter restarts after each write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur   <= 8'h00;
            r_dir   <= DIR_LEFT;
            r_count <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (r_en) begin
                        r_cur   <= r_pattern;
                        r_dir   <= DIR_LEFT;
                        r_count <= '0;
                    end
                end
                ST_WAIT_TICK: begin
                    if (r_en) begin
                        if (w_tick) begin
                            r_cur   <= w_next;
                            r_dir   <= w_next_dir;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + PERIOD_W'(1);
                        end
                    end
                end
                ST_WRITE: r_count <= '0;
                default: ;
            endcase
        end
    end

    // Sticky wrap flag; a coincident wrap event beats the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_wrap <= 1'b0;
        else if (w_wrap_evt) r_wrap <= 1'b1;
        else if (w_wrap_clr) r_wrap <= 1'b0;
    end

    // Zero-wait-state readback, unused bits read as zero
    always_comb begin
        bus.s_readdata = 32'b0;
        if (w_rd) begin
            case (bus.s_address)
                ADDR_CTRL:    bus.s_readdata = {28'd0, r_irq_en, r_mode, r_en};
                ADDR_PERIOD:  bus.s_readdata = 32'(r_period);
                ADDR_PATTERN: bus.s_readdata = {24'd0, r_pattern};
                ADDR_STATUS:  bus.s_readdata = {16'd0, r_cur, 6'd0, r_wrap, w_busy};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maoin_led_seq.sv
// Self-checking bench for maoin_led_seq: register table
// plus directed multi-cycle sequences.
module tb_maoin_led_seq;
    import maoin_led_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    maoin_led_seq_if bus ();

    maoin_led_seq #(
        .PERIOD_W     (32),
        .RESET_PERIOD (50000000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [1:0]  addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.s_address    = a;
        bus.s_writedata  = d;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(negedge clk);
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.s_address    = a;
        bus.s_chipselect = 1'b1;
        bus.s_read_n     = 1'b0;
        #1;
        d = bus.s_readdata;
        bus.s_chipselect = 1'b0;
        bus.s_read_n     = 1'b1;
    endtask

    // Wait for m_write (accepted if acc=1); n = negedges waited
    task automatic wait_write(input int limit, input bit acc,
                              output logic [31:0] d, output int n);
        n = 0;
        d = 'x;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (bus.m_write && (!acc || !bus.m_waitrequest)) begin
                d = bus.m_writedata;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_write: no write within %0d cycles", limit);
    endtask

    task automatic stop_run();
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_STATUS, 32'h2);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] st;
        logic [7:0]  pp[16];
        int          n;
        int          cnt;

        vecs[0] = '{"rst ctrl",    ADDR_CTRL,    1'b0, 32'h0,        32'h0};
        vecs[1] = '{"rst period",  ADDR_PERIOD,  1'b0, 32'h0,        32'd50000000};
        vecs[2] = '{"rst pattern", ADDR_PATTERN, 1'b0, 32'h0,        32'h1};
        vecs[3] = '{"rst status",  ADDR_STATUS,  1'b0, 32'h0,        32'h0};
        vecs[4] = '{"ctrl bits",   ADDR_CTRL,    1'b1, 32'hFFFFFFF6, 32'h6};
        vecs[5] = '{"period rw",   ADDR_PERIOD,  1'b1, 32'h12345678, 32'h12345678};
        vecs[6] = '{"pattern rw",  ADDR_PATTERN, 1'b1, 32'hABCD5A3C, 32'h3C};
        vecs[7] = '{"status ro",   ADDR_STATUS,  1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[8] = '{"ctrl clr",    ADDR_CTRL,    1'b1, 32'h0,        32'h0};
        vecs[9] = '{"pattern 01",  ADDR_PATTERN, 1'b1, 32'h1,        32'h1};

        pp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        reset_n           = 1'b0;
        bus.s_address     = 2'd0;
        bus.s_chipselect  = 1'b0;
        bus.s_write_n     = 1'b1;
        bus.s_read_n      = 1'b1;
        bus.s_writedata   = 32'h0;
        bus.m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check("rst m_write", 32'(bus.m_write), 32'h0);
        check("rst m_wdata", bus.m_writedata, 32'h0);
        check("rst irq", 32'(bus.irq), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // chaser, period 4
        bus_write(ADDR_PERIOD, 32'd4);
        bus_write(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 9; i++) begin
            wait_write(40, 1'b1, d, n);
            check("chaser data", d, (i == 8) ? 32'h1 : (32'h1 << i));
            if (i > 0) check("chaser gap", 32'(n), 32'd5);
            bus_read(ADDR_STATUS, st);
            check("chaser wrap", 32'(st[1]), 32'(i == 8));
        end
        stop_run();

        // lowering PERIOD under the running count
        bus_write(ADDR_PERIOD, 32'd20);
        bus_write(ADDR_CTRL, 32'h1);
        wait_write(40, 1'b1, d, n);
        check("lower seed", d, 32'h1);
        repeat (10) @(negedge clk);
        bus_write(ADDR_PERIOD, 32'd2);
        wait_write(40, 1'b1, d, n);
        check("lower gap", 32'(n), 32'd1);
        check("lower data", d, 32'h2);
        stop_run();

        // ping-pong, period 1
        bus_write(ADDR_PERIOD, 32'd1);
        bus_write(ADDR_CTRL, 32'h3);
        for (int i = 0; i < 16; i++) begin
            wait_write(10, 1'b1, d, n);
            check("pingpong data", d, {24'h0, pp[i]});
            bus_read(ADDR_STATUS, st);
            check("pingpong wrap", 32'(st[1]), 32'(i >= 14));
        end
        stop_run();

        // counter wrap with irq
        bus_write(ADDR_PATTERN, 32'hFE);
        bus_write(ADDR_CTRL, 32'hD);
        for (int i = 0; i < 3; i++) begin
            wait_write(10, 1'b1, d, n);
            check("counter data", d, (i == 0) ? 32'hFE : (i == 1) ? 32'hFF : 32'h0);
            check("counter irq", 32'(bus.irq), 32'(i == 2));
        end
        bus_write(ADDR_STATUS, 32'h2);
        check("irq cleared", 32'(bus.irq), 32'h0);
        stop_run();

        // wrap event and clear in the same cycle
        bus_write(ADDR_PATTERN, 32'hFF);
        bus_write(ADDR_CTRL, 32'h5);
        wait_write(10, 1'b1, d, n);
        check("coinc seed", d, 32'hFF);
        @(negedge clk);
        bus_write(ADDR_STATUS, 32'h2);
        bus_read(ADDR_STATUS, st);
        check("coinc wrap kept", st, 32'h3);
        stop_run();

        // stalled write, 7 cycles
        bus.m_waitrequest = 1'b1;
        bus_write(ADDR_PATTERN, 32'h1);
        bus_write(ADDR_PERIOD, 32'd3);
        bus_write(ADDR_CTRL, 32'h1);
        wait_write(10, 1'b0, d, n);
        for (int i = 0; i < 7; i++) begin
            check("stall m_write", 32'(bus.m_write), 32'h1);
            check("stall m_wdata", bus.m_writedata, 32'h1);
            @(negedge clk);
        end
        bus.m_waitrequest = 1'b0;
        wait_write(20, 1'b1, d, n);
        check("stall next gap", 32'(n), 32'd4);
        check("stall next data", d, 32'h2);
        stop_run();

        // EN cleared during a stalled write
        bus.m_waitrequest = 1'b1;
        bus_write(ADDR_CTRL, 32'h1);
        wait_write(10, 1'b0, d, n);
        bus_write(ADDR_CTRL, 32'h0);
        repeat (2) @(negedge clk);
        check("dis held write", 32'(bus.m_write), 32'h1);
        bus.m_waitrequest = 1'b0;
        cnt = bus.m_write ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m_write) cnt++;
        end
        check("dis write count", 32'(cnt), 32'd1);
        bus_read(ADDR_STATUS, st);
        check("dis busy", 32'(st[0]), 32'h0);

        // reset in the middle of WAIT_TICK
        bus_write(ADDR_PATTERN, 32'hFF);
        bus_write(ADDR_PERIOD, 32'd100);
        bus_write(ADDR_CTRL, 32'hD);
        wait_write(20, 1'b1, d, n);
        wait_write(200, 1'b1, d, n);
        check("pre-rst data", d, 32'h0);
        repeat (5) @(negedge clk);
        check("pre-rst irq", 32'(bus.irq), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("arst m_write", 32'(bus.m_write), 32'h0);
        check("arst m_wdata", bus.m_writedata, 32'h0);
        check("arst irq", 32'(bus.irq), 32'h0);
        bus_read(ADDR_CTRL, d);
        check("arst ctrl", d, 32'h0);
        bus_read(ADDR_PERIOD, d);
        check("arst period", d, 32'd50000000);
        bus_read(ADDR_PATTERN, d);
        check("arst pattern", d, 32'h1);
        bus_read(ADDR_STATUS, d);
        check("arst status", d, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset during a stalled write drops m_write at once
        bus.m_waitrequest = 1'b1;
        bus_write(ADDR_PERIOD, 32'd3);
        bus_write(ADDR_CTRL, 32'h1);
        wait_write(10, 1'b0, d, n);
        #2 reset_n = 1'b0;
        #1;
        check("arst mid-write", 32'(bus.m_write), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.m_waitrequest = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
